// File: rtl/f_pc_seq_pkg.sv
// Shared definitions for the F-stage next-PC sequencer.
//   RESET_PC / EXC_VECTOR : default boot PC and exception entry
//   SRC_*                 : 2-bit redirect-source code (numeric order = priority)
//   ST_*                  : sequencer state encoding
//   redirect_t            : {src, target} pair held while frozen
package mips_pc_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_BR   = 2'd1;
    localparam logic [1:0] SRC_ERET = 2'd2;
    localparam logic [1:0] SRC_EXC  = 2'd3;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] target;
    } redirect_t;

    // Source codes are ordered so that a larger code means higher priority.
    function automatic logic src_outranks(logic [1:0] a, logic [1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/f_pc_seq_if.sv
// Pipeline-side bundle of the next-PC sequencer.
//   master : the pipeline (drives PC/request inputs, receives next_pc etc.)
//   slave  : the sequencer f_pc_seq
interface f_pc_seq_if;
    logic [31:0] pc_cur;
    logic        stall;
    logic        freeze;
    logic        br_req;
    logic [31:0] br_target;
    logic        eret_req;
    logic [31:0] epc;
    logic        exc_req;
    logic [31:0] next_pc;
    logic        en_pc;
    logic        flush_fd;
    logic [1:0]  redirect_src;
    logic        fetch_adel;

    modport master (
        output pc_cur, stall, freeze, br_req, br_target, eret_req, epc, exc_req,
        input  next_pc, en_pc, flush_fd, redirect_src, fetch_adel
    );

    modport slave (
        input  pc_cur, stall, freeze, br_req, br_target, eret_req, epc, exc_req,
        output next_pc, en_pc, flush_fd, redirect_src, fetch_adel
    );
endinterface

// File: rtl/f_pc_redirect_hold.sv
// Pending-redirect register used while the pipeline is frozen.
//   clk, reset : clock, async active-low reset (clears the entry)
//   capture    : offer in_entry; loads if empty or strictly higher priority
//   clear      : drop the entry (it was applied this cycle)
//   pend_valid / pend_entry : held redirect
module f_pc_redirect_hold
    import mips_pc_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      capture,
    input  logic      clear,
    input  redirect_t in_entry,
    output logic      pend_valid,
    output redirect_t pend_entry
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_entry <= '0;
        end else if (clear) begin
            pend_valid <= 1'b0;
        end else if (capture && (!pend_valid || src_outranks(in_entry.src, pend_entry.src))) begin
            pend_valid <= 1'b1;
            pend_entry <= in_entry;
        end
    end

endmodule

// File: rtl/f_pc_seq.sv
// Next-PC sequencer/arbiter for the F-stage PC register.
//   clk, reset : clock, async active-low reset
//   bus        : f_pc_seq_if.slave -- pc_cur, stall, freeze, br/eret/exc
//                requests in; next_pc, en_pc, flush_fd, redirect_src,
//                fetch_adel out
// Priority exc > eret > br > seq. Redirects seen under freeze are held and
// applied on the first unfrozen cycle.
module f_pc_seq #(
    parameter logic [31:0] RESET_PC    = mips_pc_pkg::RESET_PC,
    parameter logic [31:0] EXC_VECTOR  = mips_pc_pkg::EXC_VECTOR,
    parameter logic [31:0] IM_BASE     = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES    = 32'h0000_4000,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    f_pc_seq_if.slave   bus
);
    import mips_pc_pkg::*;

    localparam int unsigned   CW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);
    localparam logic [32:0]   IM_LIMIT  = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] boot_cnt;
    logic          br_live;
    logic          fresh_any;
    redirect_t     fresh;
    logic          capture, clear;
    logic          pend_valid;
    redirect_t     pend_entry;

    // Under freeze a branch is captured even when stalled (freeze dominates).
    always_comb begin
        br_live   = bus.br_req & (bus.freeze | ~bus.stall);
        fresh_any = bus.exc_req | bus.eret_req | br_live;
        fresh     = '{src: SRC_SEQ, target: bus.pc_cur + 32'd4};
        if (bus.exc_req)       fresh = '{src: SRC_EXC,  target: EXC_VECTOR};
        else if (bus.eret_req) fresh = '{src: SRC_ERET, target: bus.epc};
        else if (br_live)      fresh = '{src: SRC_BR,   target: bus.br_target};
    end

    always_comb begin
        state_nxt        = state;
        bus.next_pc      = bus.pc_cur + 32'd4;
        bus.en_pc        = 1'b0;
        bus.flush_fd     = 1'b0;
        bus.redirect_src = SRC_SEQ;
        capture          = 1'b0;
        clear            = 1'b0;
        case (state)
            ST_BOOT: begin
                bus.next_pc = RESET_PC;
                if (boot_cnt == BOOT_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.freeze) begin
                    bus.next_pc = bus.pc_cur;
                    capture     = fresh_any;
                    if (fresh_any) state_nxt = ST_PEND;
                end else if (fresh_any) begin
                    bus.next_pc      = fresh.target;
                    bus.redirect_src = fresh.src;
                    bus.en_pc        = 1'b1;
                    bus.flush_fd     = 1'b1;
                end else begin
                    bus.en_pc = ~bus.stall;
                end
            end
            ST_PEND: begin
                if (bus.freeze) begin
                    bus.next_pc = bus.pc_cur;
                    capture     = fresh_any;
                end else begin
                    // A fresh exception beats whatever was held; the entry is dropped either way.
                    clear            = 1'b1;
                    state_nxt        = ST_RUN;
                    bus.en_pc        = 1'b1;
                    bus.flush_fd     = 1'b1;
                    bus.next_pc      = bus.exc_req ? EXC_VECTOR : pend_entry.target;
                    bus.redirect_src = bus.exc_req ? SRC_EXC : pend_entry.src;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        bus.fetch_adel = (state != ST_BOOT) &
                         ((bus.pc_cur[1:0] != 2'b00) |
                          (bus.pc_cur < IM_BASE) |
                          ({1'b0, bus.pc_cur} >= IM_LIMIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_BOOT) boot_cnt <= boot_cnt + CW'(1);
        end
    end

    f_pc_redirect_hold u_hold (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .clear     (clear),
        .in_entry  (fresh),
        .pend_valid(pend_valid),
        .pend_entry(pend_entry)
    );

endmodule

// File: tb/tb_f_pc_seq.sv
// Bench for f_pc_seq: directed scenarios followed by random stimulus, all
// checked against a cycle-level reference model of the sequencing rules.
module tb_f_pc_seq;

    localparam logic [31:0] RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE     = 32'h0000_3000;
    localparam logic [31:0] IM_BYTES    = 32'h0000_4000;
    localparam int          BOOT_CYCLES = 2;

    logic clk = 1'b0;
    logic reset;
    f_pc_seq_if bus();

    f_pc_seq #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR),
        .IM_BASE    (IM_BASE),
        .IM_BYTES   (IM_BYTES),
        .BOOT_CYCLES(BOOT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_boot_left = BOOT_CYCLES;
    bit          m_pv        = 1'b0;
    int          m_ps        = 0;
    logic [31:0] m_pt        = '0;

    // outputs sampled in the most recent step
    logic [31:0] s_next_pc;
    logic        s_en, s_flush, s_adel;
    logic [1:0]  s_src;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(logic [31:0] pc, bit st, bit fr, bit br, logic [31:0] bt,
                         bit er, logic [31:0] ep, bit ex);
        bus.pc_cur    = pc;
        bus.stall     = st;
        bus.freeze    = fr;
        bus.br_req    = br;
        bus.br_target = bt;
        bus.eret_req  = er;
        bus.epc       = ep;
        bus.exc_req   = ex;
    endtask

    // One clock: compare at negedge against the model, advance model at posedge.
    task automatic step();
        bit          cand_v [4];
        logic [31:0] cand_t [4];
        int          best;
        logic [31:0] best_t;
        bit          e_en, e_fl, e_adel, chk_pc;
        logic [31:0] e_pc;
        int          e_src;
        longint      pc_l;

        @(negedge clk);
        cand_v[0] = 1'b0;                 cand_t[0] = '0;
        cand_v[1] = bus.br_req && (bus.freeze || !bus.stall);
        cand_t[1] = bus.br_target;
        cand_v[2] = bus.eret_req;         cand_t[2] = bus.epc;
        cand_v[3] = bus.exc_req;          cand_t[3] = EXC_VECTOR;
        best   = 0;
        best_t = bus.pc_cur + 32'd4;
        for (int p = 1; p <= 3; p++)
            if (cand_v[p]) begin best = p; best_t = cand_t[p]; end

        pc_l   = longint'(bus.pc_cur);
        e_adel = 1'b0;
        e_src  = 0;
        e_pc   = '0;
        if (!reset || m_boot_left > 0) begin
            e_en = 0; e_fl = 0; e_pc = RESET_PC; chk_pc = 1;
        end else begin
            e_adel = (pc_l % 4 != 0) || (pc_l < longint'(IM_BASE)) ||
                     (pc_l >= longint'(IM_BASE) + longint'(IM_BYTES));
            if (bus.freeze) begin
                e_en = 0; e_fl = 0; chk_pc = 0;
            end else if (m_pv) begin
                e_en = 1; e_fl = 1; chk_pc = 1;
                if (bus.exc_req) begin e_pc = EXC_VECTOR; e_src = 3; end
                else begin e_pc = m_pt; e_src = m_ps; end
            end else begin
                e_pc  = best_t;
                e_src = best;
                e_fl  = (best != 0);
                e_en  = (best != 0) || !bus.stall;
                chk_pc = e_en;
            end
        end

        s_next_pc = bus.next_pc;
        s_en      = bus.en_pc;
        s_flush   = bus.flush_fd;
        s_src     = bus.redirect_src;
        s_adel    = bus.fetch_adel;

        check("en_pc", 32'(s_en), 32'(e_en));
        check("flush_fd", 32'(s_flush), 32'(e_fl));
        check("fetch_adel", 32'(s_adel), 32'(e_adel));
        if (chk_pc) begin
            check("next_pc", s_next_pc, e_pc);
            check("redirect_src", 32'(s_src), 32'(e_src));
        end

        @(posedge clk);
        if (!reset) begin
            m_boot_left = BOOT_CYCLES;
            m_pv        = 1'b0;
        end else if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (bus.freeze) begin
            if (best != 0 && (!m_pv || best > m_ps)) begin
                m_pv = 1'b1; m_ps = best; m_pt = best_t;
            end
        end else begin
            m_pv = 1'b0;
        end
        #1;
    endtask

    initial begin
        int flushes;
        reset = 1'b0;
        drive(32'h3000, 0, 0, 0, '0, 0, '0, 0);
        step();
        check("reset_en", 32'(s_en), 32'd0);
        check("reset_next_pc", s_next_pc, RESET_PC);
        step();
        reset = 1'b1;

        // boot delay: two cycles with en_pc low, then sequential fetch
        step();
        check("boot0_en", 32'(s_en), 32'd0);
        step();
        check("boot1_en", 32'(s_en), 32'd0);
        step();
        check("first_seq_pc", s_next_pc, 32'h3004);
        check("first_seq_en", 32'(s_en), 32'd1);

        // branch taken, zero latency
        drive(32'h3004, 0, 0, 1, 32'h3100, 0, '0, 0);
        step();
        check("br_pc", s_next_pc, 32'h3100);
        check("br_flush", 32'(s_flush), 32'd1);
        check("br_src", 32'(s_src), 32'd1);

        // stall drops the branch
        drive(32'h3100, 1, 0, 1, 32'h3300, 0, '0, 0);
        step();
        check("stall_en", 32'(s_en), 32'd0);
        check("stall_flush", 32'(s_flush), 32'd0);
        drive(32'h3100, 0, 0, 0, '0, 0, '0, 0);
        step();
        check("after_stall_pc", s_next_pc, 32'h3104);

        // freeze with branch, then exception, then release
        flushes = 0;
        drive(32'h3104, 0, 1, 1, 32'h3200, 0, '0, 0);
        step(); flushes += int'(s_flush);
        drive(32'h3104, 0, 1, 0, '0, 0, '0, 1);
        step(); flushes += int'(s_flush);
        drive(32'h3104, 0, 0, 0, '0, 0, '0, 0);
        step(); flushes += int'(s_flush);
        check("pend_release_pc", s_next_pc, EXC_VECTOR);
        check("pend_release_src", 32'(s_src), 32'd3);
        drive(32'h4180, 0, 0, 0, '0, 0, '0, 0);
        step(); flushes += int'(s_flush);
        check("pend_single_flush", 32'(flushes), 32'd1);

        // exc beats eret; eret alone
        drive(32'h4180, 0, 0, 0, '0, 1, 32'h3010, 1);
        step();
        check("exc_over_eret", s_next_pc, EXC_VECTOR);
        drive(32'h4180, 0, 0, 0, '0, 1, 32'h3010, 0);
        step();
        check("eret_pc", s_next_pc, 32'h3010);
        check("eret_src", 32'(s_src), 32'd2);

        // fetch address error boundaries
        drive(32'h3002, 0, 0, 0, '0, 0, '0, 0); step();
        check("adel_misalign", 32'(s_adel), 32'd1);
        drive(32'h7000, 0, 0, 0, '0, 0, '0, 0); step();
        check("adel_top", 32'(s_adel), 32'd1);
        drive(32'h6ffc, 0, 0, 0, '0, 0, '0, 0); step();
        check("adel_last_ok", 32'(s_adel), 32'd0);
        drive(32'h2ffc, 0, 0, 0, '0, 0, '0, 0); step();
        check("adel_below", 32'(s_adel), 32'd1);
        drive(32'hffff_fffc, 0, 0, 0, '0, 0, '0, 0); step();
        check("seq_wrap_pc", s_next_pc, 32'h0000_0000);

        // reset while a redirect is pending discards it
        drive(32'h3000, 0, 1, 1, 32'h3500, 0, '0, 0);
        step();
        reset = 1'b0;
        drive(32'h3000, 0, 0, 0, '0, 0, '0, 0);
        step();
        check("pend_reset_en", 32'(s_en), 32'd0);
        reset = 1'b1;
        step(); step();
        check("pend_reset_boot_en", 32'(s_en), 32'd0);
        step();
        check("pend_reset_seq_pc", s_next_pc, 32'h3004);
        check("pend_reset_flush", 32'(s_flush), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            if ($urandom_range(0, 9) == 0) pc = $urandom();
            else pc = IM_BASE + 32'($urandom_range(0, 32'hfff)) * 32'd4;
            reset = ($urandom_range(0, 199) != 0);
            drive(pc,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 3,
                  IM_BASE + 32'($urandom_range(0, 32'hfff)) * 32'd4,
                  $urandom_range(0, 9) == 0,
                  IM_BASE + 32'($urandom_range(0, 32'hfff)) * 32'd4,
                  $urandom_range(0, 11) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
